// File: rtl/barrett_3343_pkg.sv
// Constants and helpers for the shared mod-3343 Barrett reduction datapath.
package barrett_3343_pkg;

   localparam int unsigned Q       = 3343;
   localparam int unsigned MU      = 5018;
   localparam int unsigned SHIFT_A = 12;
   localparam int unsigned SHIFT_B = 12;
   localparam int unsigned DIN_W   = 23;
   localparam int unsigned DOUT_W  = 12;
   localparam int unsigned QH_W    = 24;
   localparam int unsigned T_W     = QH_W - SHIFT_B;
   localparam int unsigned R0_W    = 14;

   // Number of Q multiples to remove from a partial residue in [0, 4*Q).
   function automatic logic [1:0] corr_sel(input logic [R0_W-1:0] r0);
      logic [1:0] k;
      if (r0 >= R0_W'(3 * Q))
         k = 2'd3;
      else if (r0 >= R0_W'(2 * Q))
         k = 2'd2;
      else if (r0 >= R0_W'(Q))
         k = 2'd1;
      else
         k = 2'd0;
      return k;
   endfunction

endpackage

// File: rtl/barrett_3343_arbiter_if.sv
// Request/response bundle between the NTT lanes and the shared reducer.
interface barrett_3343_arbiter_if
   import barrett_3343_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*DIN_W-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     out_valid;
   logic                     out_ready;
   logic [DOUT_W-1:0]        out_data;
   logic [ID_W-1:0]          out_id;
   logic                     busy;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, busy
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id, busy
   );

endinterface

// File: rtl/barrett_3343_pipe.sv
// Three-stage Barrett datapath: quotient estimate, partial residue, final correction.
module barrett_3343_pipe
   import barrett_3343_pkg::*;
#(
   parameter int unsigned ID_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              in_valid,
   input  logic [DIN_W-1:0]  din,
   input  logic [ID_W-1:0]   id,
   output logic              valid,
   output logic [DOUT_W-1:0] residue,
   output logic [ID_W-1:0]   tag,
   output logic              busy
);

   logic              s1_valid;
   logic [R0_W-1:0]   s1_lo;
   logic [T_W-1:0]    s1_t;
   logic [ID_W-1:0]   s1_id;
   logic              s2_valid;
   logic [R0_W-1:0]   s2_r0;
   logic [ID_W-1:0]   s2_id;

   // r0 is known to fit in 14 bits, so the subtraction only needs the low
   // 14 bits of din and t*Q; S1 keeps just those plus the top half of qh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_lo    <= '0;
         s1_t     <= '0;
         s1_id    <= '0;
         s2_valid <= 1'b0;
         s2_r0    <= '0;
         s2_id    <= '0;
         valid    <= 1'b0;
         residue  <= '0;
         tag      <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_lo <= din[R0_W-1:0];
            s1_t  <= T_W'((QH_W'(din[DIN_W-1:SHIFT_A]) * QH_W'(MU)) >> SHIFT_B);
            s1_id <= id;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_r0 <= s1_lo - R0_W'(s1_t) * R0_W'(Q);
            s2_id <= s1_id;
         end
         valid <= s2_valid;
         if (s2_valid) begin
            residue <= DOUT_W'(s2_r0) - DOUT_W'(corr_sel(s2_r0)) * DOUT_W'(Q);
            tag     <= s2_id;
         end
      end
   end

   always_comb begin
      busy = s1_valid | s2_valid | valid;
   end

endmodule

// File: rtl/barrett_3343_arbiter.sv
// Round-robin front end sharing one mod-3343 Barrett pipeline among NUM_REQ lanes.
module barrett_3343_arbiter
   import barrett_3343_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   barrett_3343_arbiter_if.slave bus
);

   logic              stall;
   logic              hit;
   logic              xfer;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   idx;
   logic [ID_W-1:0]   gnt;
   logic [DIN_W-1:0]  din_sel;
   logic              pipe_valid;
   logic [DOUT_W-1:0] pipe_residue;
   logic [ID_W-1:0]   pipe_tag;
   logic              pipe_busy;

   always_comb begin
      stall = bus.out_valid && !bus.out_ready;
      hit   = 1'b0;
      idx   = '0;
      gnt   = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = ID_W'((32'(ptr) + off) % NUM_REQ);
         if (!hit && bus.req_valid[idx]) begin
            hit = 1'b1;
            gnt = idx;
         end
      end
      // Gating with rst_n keeps req_ready low for the whole reset window.
      xfer = hit && !stall && rst_n;
      bus.req_ready = '0;
      if (xfer)
         bus.req_ready[gnt] = 1'b1;
      din_sel = bus.req_data[32'(gnt) * DIN_W +: DIN_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (xfer)
         ptr <= (32'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
   end

   barrett_3343_pipe #(.ID_W(ID_W)) u_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (!stall),
      .in_valid (xfer),
      .din      (din_sel),
      .id       (gnt),
      .valid    (pipe_valid),
      .residue  (pipe_residue),
      .tag      (pipe_tag),
      .busy     (pipe_busy)
   );

   always_comb begin
      bus.out_valid = pipe_valid;
      bus.out_data  = pipe_residue;
      bus.out_id    = pipe_tag;
      bus.busy      = pipe_busy;
   end

endmodule

// File: tb/tb_barrett_3343_arbiter.sv
// Bench for barrett_3343_arbiter: directed scenarios plus a random sweep against a queue-based model.
module tb_barrett_3343_arbiter;
   import barrett_3343_pkg::*;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int CAP = 4096;

   typedef struct {
      int unsigned res;
      int unsigned id;
      int          p;
   } ent_t;

   typedef struct {
      int unsigned data;
      int unsigned id;
      int          cyc;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;

   barrett_3343_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

   barrett_3343_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   ent_t        mq[$];
   obs_t        out_log[$];
   int          grant_log[$];
   int          ptr_m = 0;
   int          ptime = 0;
   int          cyc = 0;
   int          first_ov_cyc = -1;
   int          last_acc_cyc = -1;
   int unsigned first_ov_data = 0;
   int unsigned lane_mem[N][CAP];
   int          lane_wr[N];
   int          lane_rd[N];
   bit          presenting[N];
   bit          gaps = 1'b0;
   bit          rand_ready = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_out_data"},  32'(bus.out_data), 0);
      chk({tag, "_out_id"},    32'(bus.out_id), 0);
      chk({tag, "_busy"},      32'(bus.busy), 0);
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
   endtask

   task automatic push(input int lane, input int unsigned val);
      lane_mem[lane][lane_wr[lane] % CAP] = val;
      lane_wr[lane]++;
   endtask

   function automatic int pending();
      int c = 0;
      for (int i = 0; i < N; i++)
         c += lane_wr[i] - lane_rd[i];
      return c;
   endfunction

   task automatic drive();
      logic [N*DIN_W-1:0] d;
      logic [N-1:0]       v;
      d = '0;
      v = '0;
      for (int i = 0; i < N; i++) begin
         if (!presenting[i] && lane_rd[i] != lane_wr[i] && (!gaps || $urandom_range(1, 0) == 1))
            presenting[i] = 1'b1;
         if (presenting[i]) begin
            v[i] = 1'b1;
            d[i*DIN_W +: DIN_W] = DIN_W'(lane_mem[i][lane_rd[i] % CAP]);
         end
      end
      bus.req_valid = v;
      bus.req_data  = d;
      if (rand_ready)
         bus.out_ready = ($urandom_range(3, 0) != 0);
   endtask

   // Model: every accepted operand needs three unstalled cycles to reach the
   // output; the whole pipe freezes while the output is held.
   task automatic check_model();
      bit exp_ov;
      bit stall_m;
      int g;
      int exp_rdy;
      cyc++;
      if (!rst_n) begin
         mq.delete();
         ptr_m = 0;
         ptime = 0;
         chk_reset_state("in_reset");
         return;
      end
      exp_ov = (mq.size() > 0) && (mq[0].p + 3 <= ptime);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("busy", 32'(bus.busy), 32'(mq.size() != 0));
      if (bus.out_valid === 1'b1 && first_ov_cyc < 0) begin
         first_ov_cyc  = cyc;
         first_ov_data = 32'(bus.out_data);
      end
      if (exp_ov) begin
         chk("out_data", 32'(bus.out_data), mq[0].res);
         chk("out_id", 32'(bus.out_id), mq[0].id);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
         out_log.push_back('{data: 32'(bus.out_data), id: 32'(bus.out_id), cyc: cyc});
      stall_m = exp_ov && !bus.out_ready;
      g = -1;
      if (!stall_m) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr_m + k) % N;
            if (g < 0 && presenting[i])
               g = i;
         end
      end
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      chk("req_ready", 32'(bus.req_ready), exp_rdy);
      if (exp_ov && bus.out_ready)
         void'(mq.pop_front());
      if (g >= 0) begin
         mq.push_back('{res: lane_mem[g][lane_rd[g] % CAP] % Q, id: g, p: ptime});
         lane_rd[g]++;
         presenting[g] = 1'b0;
         ptr_m = (g + 1) % N;
         grant_log.push_back(g);
         last_acc_cyc = cyc;
      end
      if (!stall_m)
         ptime++;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_model();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((pending() != 0 || mq.size() != 0) && n < 20000) begin
         cycle();
         n++;
      end
      chk({tag, "_drained"}, 32'(pending() + mq.size()), 0);
      chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned bnd_exp[5];
      int unsigned bnd_tab[14];
      bnd_exp = '{0, 3342, 0, 3342, 0};
      bnd_tab = '{0, 1, 3342, 3343, 3344, 6685, 6686, 10028, 10029, 13371, 13372,
                  8388607, 8388606, 8387587};
      for (int i = 0; i < N; i++) begin
         lane_wr[i]    = 0;
         lane_rd[i]    = 0;
         presenting[i] = 1'b0;
      end
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.out_ready = 1'b1;

      // Reset state, with a request already waiting on lane 0.
      push(0, 8388607);
      drive();
      #2;
      chk_reset_state("por");
      repeat (2) cycle();
      rst_n = 1'b1;

      // Single operand: largest input, three-cycle latency.
      for (int n = 0; n < 8; n++)
         cycle();
      chk("latency", 32'(first_ov_cyc - last_acc_cyc), 3);
      chk("max_operand", first_ov_data, 1020);

      // Residue boundaries back-to-back on lane 1.
      out_log.delete();
      for (int k = 0; k < 5; k++)
         push(1, (k == 0) ? 0 : (k == 1) ? 3342 : (k == 2) ? 3343 : (k == 3) ? 6685 : 6686);
      drive();
      drain("bnd");
      chk("bnd_count", 32'(out_log.size()), 5);
      for (int k = 0; k < 5 && k < out_log.size(); k++) begin
         chk("bnd_data", out_log[k].data, bnd_exp[k]);
         chk("bnd_id", out_log[k].id, 1);
         if (k > 0)
            chk("bnd_spacing", 32'(out_log[k].cyc - out_log[k-1].cyc), 1);
      end

      // Output stall with three entries in flight and another lane waiting.
      out_log.delete();
      for (int k = 0; k < 3; k++)
         push(2, $urandom & 32'h7FFFFF);
      drive();
      repeat (3) cycle();
      bus.out_ready = 1'b0;
      push(3, $urandom & 32'h7FFFFF);
      drive();
      repeat (5) cycle();
      chk("stall_no_output", 32'(out_log.size()), 0);
      bus.out_ready = 1'b1;
      drive();
      drain("stall");
      chk("stall_count", 32'(out_log.size()), 4);
      for (int k = 0; k < 4 && k < out_log.size(); k++)
         chk("stall_id", out_log[k].id, (k < 3) ? 2 : 3);

      // Reset in the middle of traffic, then all lanes requesting continuously.
      for (int k = 0; k < 3; k++)
         push(0, $urandom & 32'h7FFFFF);
      drive();
      repeat (3) cycle();
      push(1, $urandom & 32'h7FFFFF);
      drive();
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_state("midflight");
      repeat (2) cycle();
      rst_n = 1'b1;
      out_log.delete();
      grant_log.delete();
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < N; i++)
            push(i, $urandom & 32'h7FFFFF);
      drive();
      drain("rr");
      chk("rr_count", 32'(out_log.size()), 33);
      for (int k = 0; k < 32 && k < grant_log.size(); k++)
         chk("rr_order", 32'(grant_log[k]), k % N);
      for (int k = 1; k < 32 && k < out_log.size(); k++)
         chk("rr_spacing", 32'(out_log[k].cyc - out_log[k-1].cyc), 1);

      // Random sweep with request gaps and output back-pressure.
      gaps       = 1'b1;
      rand_ready = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         int unsigned v;
         if ($urandom_range(9, 0) == 0)
            v = bnd_tab[$urandom_range(13, 0)];
         else
            v = $urandom & 32'h7FFFFF;
         push($urandom_range(N - 1, 0), v);
      end
      drive();
      drain("rand");
      rand_ready    = 1'b0;
      bus.out_ready = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
